// File: rtl/fpga_cfg_pkg.sv
// Shared constants and state encoding for the switch-box configuration loader.
package fpga_cfg_pkg;

    localparam int CFG_W      = 16;
    localparam int SEL_W      = 2;
    localparam int NUM_FIELDS = 8;
    localparam logic [SEL_W-1:0] SEL_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } cfg_state_t;

endpackage

// File: rtl/cfg_field_check.sv
// Combinational mux-select sanitiser: zeroes every illegal 2-bit field and flags it.
module cfg_field_check
    import fpga_cfg_pkg::*;
(
    input  logic [CFG_W-1:0] word,
    output logic [CFG_W-1:0] clean,
    output logic             illegal
);

    logic [NUM_FIELDS-1:0] bad;

    for (genvar g = 0; g < NUM_FIELDS; g++) begin : g_field
        logic [SEL_W-1:0] sel;
        assign sel    = word[g*SEL_W +: SEL_W];
        assign bad[g] = (sel == SEL_ILLEGAL);
        assign clean[g*SEL_W +: SEL_W] = bad[g] ? '0 : sel;
    end

    assign illegal = |bad;

endmodule

// File: rtl/sb_config_loader.sv
// Streams sanitised config words to switch boxes 0..NUM_TILES-1 via a shared bus
// and a one-hot registered write strobe.
module sb_config_loader #(
    parameter int NUM_TILES = 4,
    parameter int CFG_W     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 cfg_valid,
    input  logic [CFG_W-1:0]     cfg_data,
    output logic                 cfg_ready,
    output logic [CFG_W-1:0]     sb_cfg_data,
    output logic [NUM_TILES-1:0] sb_cfg_en,
    output logic                 busy,
    output logic                 done,
    output logic                 cfg_err
);

    import fpga_cfg_pkg::*;

    localparam int IDX_W = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_TILES - 1);

    cfg_state_t             state;
    logic [IDX_W-1:0]       tile_idx;
    logic [CFG_W-1:0]       clean;
    logic                   illegal;
    logic [NUM_TILES-1:0]   onehot;

    cfg_field_check u_check (
        .word    (cfg_data),
        .clean   (clean),
        .illegal (illegal)
    );

    assign cfg_ready = (state == LOAD);
    assign busy      = (state == LOAD);

    always_comb begin
        onehot           = '0;
        onehot[tile_idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            tile_idx    <= '0;
            sb_cfg_data <= '0;
            sb_cfg_en   <= '0;
            done        <= 1'b0;
            cfg_err     <= 1'b0;
        end else begin
            // Strobe and done are single-cycle pulses unless re-armed below
            sb_cfg_en <= '0;
            done      <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= LOAD;
                        tile_idx <= '0;
                        cfg_err  <= 1'b0;
                    end
                end
                LOAD: begin
                    if (cfg_valid) begin
                        sb_cfg_data <= clean;
                        sb_cfg_en   <= onehot;
                        if (illegal)
                            cfg_err <= 1'b1;
                        if (tile_idx == LAST_IDX) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            tile_idx <= tile_idx + IDX_W'(1);
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/sb_config_loader.md
# sb_config_loader

Configuration writer for the switch-box fabric. Accepts a stream of 16-bit switch-box configuration words over a valid/ready handshake after a `start` pulse. Delivers each word to one tile's switch box through a shared data bus and a one-hot write strobe, in tile order 0..NUM_TILES-1. Sits between the bitstream source and the switch-box config registers. Sanitises illegal mux selects and flags them.

## Interface
Parameters:
- `NUM_TILES`, 4: number of switch boxes on the config bus; legal range 2..64.
- `CFG_W`, 16: config word width; fixed at 8 fields × 2-bit mux select.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: single-cycle request to begin a load; ignored unless state is IDLE.
- `cfg_valid`, in, 1: source has a word on `cfg_data`.
- `cfg_data`, in, CFG_W: config word; bits [15:14] are field 7 … bits [1:0] are field 0.
- `cfg_ready`, out, 1: loader accepts a word this cycle.
- `sb_cfg_data`, out, CFG_W: sanitised word for the switch boxes.
- `sb_cfg_en`, out, NUM_TILES: one-hot write strobe; bit i loads tile i.
- `busy`, out, 1: high in LOAD.
- `done`, out, 1: one-cycle pulse when the last tile has been written.
- `cfg_err`, out, 1: sticky flag; at least one illegal field was seen in the current or last load.

## Operation
- States: IDLE, LOAD, DONE.
  - IDLE → LOAD on `start`. On the same edge: `tile_idx` ← 0 and `cfg_err` ← 0.
  - LOAD → DONE on the edge that accepts the word with `tile_idx == NUM_TILES-1`.
  - DONE → IDLE unconditionally after one cycle.
- `cfg_ready` = (state == LOAD). It is combinational from state only and never depends on `cfg_valid`.
- Acceptance occurs when `cfg_valid && cfg_ready` at a rising edge. `tile_idx` then increments by 1. Width is $clog2(NUM_TILES), with no wrap inside a load.
- `cfg_valid` low in LOAD: stall indefinitely. `sb_cfg_en` stays 0 and there is no timeout.
- Sanitising: each 2-bit field equal to 2'b11 is forced to 2'b00 in `sb_cfg_data`. Any such field sets `cfg_err` on the accept edge. Other fields pass unchanged.
- `start` in LOAD or DONE: ignored and has no effect on the count.
- `cfg_err` holds through DONE and IDLE. It clears only on the next accepted `start` or on reset.
- Reset is asserted asynchronously and may come mid-load:
  - State goes to IDLE and `tile_idx` to 0.
  - All outputs go to 0.
  - There is no partial-completion indication. The system must reload all tiles.

## Timing
- Reset values: `cfg_ready`=0, `sb_cfg_data`=0, `sb_cfg_en`=0, `busy`=0, `done`=0, `cfg_err`=0.
- `start` at edge S: `busy` and `cfg_ready` are high from cycle S+1.
- Word accepted at edge N:
  - `sb_cfg_data` and `sb_cfg_en[idx]` are registered and valid for exactly cycle N+1.
  - `sb_cfg_en` is 0 in every other cycle.
- Back-to-back: with `cfg_valid` held high, one tile is written per cycle. A full load takes NUM_TILES cycles of `cfg_ready`.
- Last word accepted at edge L:
  - `cfg_ready` and `busy` are 0 from cycle L+1.
  - The last `sb_cfg_en` strobe is in cycle L+1.
  - `done` = 1 in cycle L+1 only, in the same cycle as the last strobe.
- `start` accepted again no earlier than edge L+2.
- All outputs are registered except `cfg_ready` and `busy`, which are decoded from the state register.

## Structure
- Package `fpga_cfg_pkg`:
  - Constants `CFG_W`=16, `SEL_W`=2, `SEL_ILLEGAL`=2'b11, and `NUM_FIELDS`=8.
  - State enum `cfg_state_t` {IDLE, LOAD, DONE}.
- Sub-module `cfg_field_check`: combinational. Takes a CFG_W word and returns the sanitised word plus a 1-bit `illegal` flag, implemented as a generate loop over NUM_FIELDS.
- The top level holds the FSM, the tile counter, the one-hot decode, and the output registers.

## Test plan
- Reset mid-load: NUM_TILES=4, accept 2 words, assert `reset` low between edges → all outputs 0 immediately. After release, `start` plus 4 words writes tiles 0..3 from scratch.
- Back-to-back load: `start`, then 16'h1248, 16'h0000, 16'h2A2A, 16'h9999 with `cfg_valid` held high →
  - `sb_cfg_en` = 0001, 0010, 0100, 1000 in consecutive cycles with matching data.
  - `done` pulses with the 1000 strobe.
  - `cfg_err`=0.
- Illegal fields: word 16'hFFFF to tile 0 → `sb_cfg_data`=16'h0000 and `cfg_err`=1 until the next `start`. Word 16'hC001 → 16'h0001.
- Stalls: `cfg_valid` toggling 1,0,0,1,0,1,1 → exactly 4 strobes, each one cycle after its accept edge, with no strobe in stall cycles.
- Ignored start: `start` pulsed during LOAD after 1 accepted word → the count continues and the remaining 3 words go to tiles 1..3.
